// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO; frames go out back-to-back while data is queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8,
    localparam int W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   pi_data,
    input  logic         pi_flag,
    output logic         line_tx,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         fifo_full,
    output logic [W-1:0] fifo_cnt,
    output logic         ovf
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int BW      = $clog2(BIT_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [W-1:0]  r_cnt;
    logic          r_ovf;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_line, r_done;
    logic          w_wr, w_pop, w_has, w_bit_end;

    assign w_has     = r_cnt != '0;
    assign fifo_full = r_cnt == W'(FIFO_DEPTH);
    assign w_wr      = pi_flag && !fifo_full;
    assign w_bit_end = r_baud == BW'(BIT_CNT - 1);
    // Pop decisions use the count before the edge, so a same-cycle write never feeds an empty pop.
    assign w_pop     = w_has && (r_state == IDLE || (r_state == STOP && w_bit_end));

    assign line_tx  = r_line;
    assign tx_done  = r_done;
    assign tx_busy  = r_state != IDLE || w_has;
    assign fifo_cnt = r_cnt;
    assign ovf      = r_ovf;

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr_ptr] <= pi_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + W'(w_wr) - W'(w_pop);
            r_ovf <= pi_flag && fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_state == STOP && r_baud == BW'(BIT_CNT - 2);
            r_baud <= (r_state == IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
            case (r_state)
                IDLE:
                    if (w_has) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_line  <= 1'b0;
                        r_state <= START;
                    end
                START:
                    if (w_bit_end) begin
                        r_line  <= r_shift[0];
                        r_state <= DATA;
                    end
                DATA:
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + 1'b1;
                        r_line  <= (r_idx == 3'd7) ? 1'b1 : r_shift[1];
                        r_state <= (r_idx == 3'd7) ? STOP : DATA;
                    end
                STOP:
                    if (w_bit_end) begin
                        if (w_has) r_shift <= r_mem[r_rd_ptr];
                        r_line  <= !w_has;
                        r_state <= w_has ? START : IDLE;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line monitor decodes frames and compares them against queued bytes.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pi_flag = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       line_tx, tx_busy, tx_done, fifo_full, ovf;
    logic [2:0] fifo_cnt;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pi_data(pi_data), .pi_flag(pi_flag),
        .line_tx(line_tx), .tx_busy(tx_busy), .tx_done(tx_done),
        .fifo_full(fifo_full), .fifo_cnt(fifo_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    int done_n = 0, last_done = 0, prev_done = 0, ovf_n = 0, epoch = 0;
    logic mon_en = 1'b0, mon_busy = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (tx_done) begin
            done_n    <= done_n + 1;
            prev_done <= last_done;
            last_done <= cyc;
        end

    always @(negedge clk)
        if (ovf) ovf_n <= ovf_n + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit acc);
        pi_data = d;
        pi_flag = 1'b1;
        if (acc) exp_q.push_back(d);
        @(negedge clk);
        pi_flag = 1'b0;
    endtask

    task automatic drain(input string tag, input int lim);
        int k;
        k = 0;
        while ((tx_busy || exp_q.size() != 0 || mon_busy) && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(k >= lim), 0);
    endtask

    // Samples each bit near its middle; frames started before a reset are discarded.
    initial begin
        logic [7:0] b;
        logic s0, s1;
        int ep;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!line_tx) begin
                mon_busy = 1'b1;
                ep = epoch;
                repeat (4) @(negedge clk);
                s0 = line_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = line_tx;
                end
                repeat (10) @(negedge clk);
                s1 = line_tx;
                if (ep == epoch) begin
                    check("start_bit", 32'(s0), 0);
                    check("stop_bit", 32'(s1), 1);
                    if (exp_q.size() == 0) check("extra_byte", 32'(b), 32'h100);
                    else check("byte", 32'(b), 32'(exp_q.pop_front()));
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int n, ov0;
        repeat (3) @(negedge clk);
        check("rst_line", 32'(line_tx), 1);
        check("rst_busy", 32'(tx_busy), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_cnt", 32'(fifo_cnt), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("idle_line", 32'(line_tx), 1);
            check("idle_busy", 32'(tx_busy), 0);
            check("idle_cnt", 32'(fifo_cnt), 0);
        end

        push(8'hA5, 1'b1);
        n = cyc;
        check("t2_line_pre", 32'(line_tx), 1);
        while (cyc < n + 1) @(negedge clk);
        check("t2_start", 32'(line_tx), 0);
        while (cyc < n + 100) @(negedge clk);
        check("t2_done", 32'(tx_done), 1);
        check("t2_busy_hi", 32'(tx_busy), 1);
        @(negedge clk);
        check("t2_done_off", 32'(tx_done), 0);
        check("t2_busy_lo", 32'(tx_busy), 0);
        check("t2_done_cyc", 32'(last_done), 32'(n + 100));
        check("t2_done_n", 32'(done_n), 1);
        drain("t2_drain", 300);

        push(8'h55, 1'b1);
        n = cyc;
        push(8'h0F, 1'b1);
        while (cyc < n + 101) @(negedge clk);
        check("t3_second_start", 32'(line_tx), 0);
        while (cyc < n + 202) @(negedge clk);
        check("t3_done_gap", 32'(last_done - prev_done), 100);
        check("t3_done_cyc", 32'(last_done), 32'(n + 200));
        drain("t3_drain", 400);

        ov0 = ovf_n;
        for (int i = 1; i <= 6; i++) push(8'(i), i <= 5);
        check("t4_ovf", 32'(ovf), 1);
        check("t4_full", 32'(fifo_full), 1);
        check("t4_cnt", 32'(fifo_cnt), 4);
        @(negedge clk);
        check("t4_ovf_off", 32'(ovf), 0);
        drain("t4_drain", 1000);
        check("t4_ovf_n", 32'(ovf_n - ov0), 1);

        push(8'h00, 1'b1);
        n = cyc;
        while (cyc < n + 35) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        epoch++;
        check("t5_line", 32'(line_tx), 1);
        check("t5_cnt", 32'(fifo_cnt), 0);
        check("t5_busy", 32'(tx_busy), 0);
        repeat (120) @(negedge clk);
        push(8'h81, 1'b1);
        drain("t5_drain", 300);

        push(8'h96, 1'b1);
        n = cyc;
        while (cyc < n + 100) @(negedge clk);
        pi_data = 8'h3C;
        pi_flag = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        pi_flag = 1'b0;
        check("t6_gap_line", 32'(line_tx), 1);
        check("t6_cnt", 32'(fifo_cnt), 1);
        @(negedge clk);
        check("t6_start", 32'(line_tx), 0);
        drain("t6_drain", 300);
        check("final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
